radix_sort_lsd: RTL and testbench

Parametrised multi-pass LSD radix sorter for AXI-Stream key frames. It is the generalised successor to the fixed 10-bit-digit sorter and keeps the same stream interface. It adds:
- configurable digit width and pass count,
- runtime ascending/descending order,
- stable ordering,
- overflow reporting for oversized frames.

It sits between a stream producer and consumer as a frame-buffered sort stage.

---
 rtl/radix_sort_pkg.sv | 24 ++
 rtl/radix_hist.sv | 54 +++++
 rtl/radix_sort_lsd.sv | 223 ++++++++++++++++++++++
 tb/tb_radix_sort_lsd.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix_sort_pkg.sv
// Shared types and sizing helpers for the LSD radix sorter.
package radix_sort_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLR,
    ST_HIST,
    ST_PREFIX,
    ST_SCATTER,
    ST_OUT
  } state_e;

  localparam int unsigned N_MAX_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT = $clog2(N_MAX_DEFAULT + 1);

  function automatic int unsigned num_passes(input int unsigned width, input int unsigned radix);
    return (width + radix - 1) / radix;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n_max);
    return $clog2(n_max + 1);
  endfunction

endpackage

// File: rtl/radix_hist.sv
// Digit histogram: clear, count, exclusive-prefix walk, and offset post-increment.
module radix_hist
  import radix_sort_pkg::*;
#(
  parameter int unsigned RADIX_BITS_P = 4,
  parameter int unsigned CNT_W_P      = CNT_W_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    inc_i,
  input  logic [RADIX_BITS_P-1:0] digit_i,
  input  logic                    walk_i,
  input  logic [RADIX_BITS_P-1:0] walk_bin_i,
  input  logic                    post_inc_i,
  input  logic [RADIX_BITS_P-1:0] post_digit_i,
  output logic [CNT_W_P-1:0]      off_c
);

  localparam int unsigned BINS = 1 << RADIX_BITS_P;

  logic [CNT_W_P-1:0] cnt_q [BINS];
  logic [CNT_W_P-1:0] cnt_d [BINS];
  logic [CNT_W_P-1:0] acc_q, acc_d;

  // Walk rewrites each count in place with the running sum of the bins before it.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clr_i) begin
      for (int unsigned b = 0; b < BINS; b++) cnt_d[b] = '0;
      acc_d = '0;
    end else if (walk_i) begin
      cnt_d[walk_bin_i] = acc_q;
      acc_d             = acc_q + cnt_q[walk_bin_i];
    end else if (inc_i) begin
      cnt_d[digit_i] = cnt_q[digit_i] + CNT_W_P'(1);
    end else if (post_inc_i) begin
      cnt_d[post_digit_i] = cnt_q[post_digit_i] + CNT_W_P'(1);
    end
  end

  assign off_c = cnt_q[post_digit_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/radix_sort_lsd.sv
// Frame-buffered multi-pass LSD radix sorter on AXI-Stream keys.
module radix_sort_lsd
  import radix_sort_pkg::*;
#(
  parameter int unsigned WIDTH_P      = 16,
  parameter int unsigned RADIX_BITS_P = 4,
  parameter int unsigned N_MAX_P      = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               descend_i,
  input  logic [WIDTH_P-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [WIDTH_P-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy_o,
  output logic               overflow_o
);

  localparam int unsigned PASSES = num_passes(WIDTH_P, RADIX_BITS_P);
  localparam int unsigned CW     = cnt_width(N_MAX_P);
  localparam int unsigned IW     = (N_MAX_P > 1) ? $clog2(N_MAX_P) : 1;
  localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned XW     = WIDTH_P + RADIX_BITS_P;

  state_e                  state_q, state_d;
  logic [CW-1:0]           n_q, n_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic [RADIX_BITS_P-1:0] bin_q, bin_d;
  logic                    sel_q, sel_d;
  logic                    desc_q, desc_d;
  logic                    overflow_q, overflow_d;
  logic                    busy_q, busy_d;
  logic                    s_tready_q, s_tready_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [WIDTH_P-1:0]      m_tdata_q, m_tdata_d;
  logic [WIDTH_P-1:0]      buf_q [2][N_MAX_P];
  logic [WIDTH_P-1:0]      buf_d [2][N_MAX_P];

  logic                    h_clr, h_inc, h_walk, h_post;
  logic [RADIX_BITS_P-1:0] h_bin, cur_digit;
  logic [CW-1:0]           h_off_c;
  logic [WIDTH_P-1:0]      src_key;
  logic                    in_hs, out_hs;

  // Zero-extend before shifting so a narrow final digit reads zeros above the key.
  function automatic logic [RADIX_BITS_P-1:0] digit_of(input logic [WIDTH_P-1:0] key,
                                                        input logic [PW-1:0]      pass);
    logic [XW-1:0] ext;
    ext = XW'(key) >> (32'(pass) * RADIX_BITS_P);
    return ext[RADIX_BITS_P-1:0];
  endfunction

  assign in_hs     = s_tvalid && s_tready_q;
  assign out_hs    = m_tvalid_q && m_tready;
  assign src_key   = buf_q[sel_q][IW'(idx_q)];
  assign cur_digit = digit_of(src_key, pass_q);
  assign h_bin     = desc_q ? ~bin_q : bin_q;

  radix_hist #(
    .RADIX_BITS_P(RADIX_BITS_P),
    .CNT_W_P     (CW)
  ) u_hist (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (h_clr),
    .inc_i       (h_inc),
    .digit_i     (cur_digit),
    .walk_i      (h_walk),
    .walk_bin_i  (h_bin),
    .post_inc_i  (h_post),
    .post_digit_i(cur_digit),
    .off_c       (h_off_c)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    bin_d      = bin_q;
    sel_d      = sel_q;
    desc_d     = desc_q;
    overflow_d = overflow_q;
    buf_d      = buf_q;
    h_clr      = 1'b0;
    h_inc      = 1'b0;
    h_walk     = 1'b0;
    h_post     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          if (n_q == '0) begin
            desc_d     = descend_i;
            overflow_d = 1'b0;
          end
          // Beats past capacity are swallowed so the producer never stalls.
          if (n_q == CW'(N_MAX_P)) begin
            overflow_d = 1'b1;
          end else begin
            buf_d[1'b0][IW'(n_q)] = s_tdata;
            n_d                   = n_q + CW'(1);
          end
          if (s_tlast) begin
            state_d = ST_CLR;
            pass_d  = '0;
            sel_d   = 1'b0;
          end
        end
      end
      ST_CLR: begin
        h_clr   = 1'b1;
        idx_d   = '0;
        bin_d   = '0;
        state_d = ST_HIST;
      end
      ST_HIST: begin
        h_inc = 1'b1;
        if (idx_q == n_q - CW'(1)) begin
          idx_d   = '0;
          state_d = ST_PREFIX;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_PREFIX: begin
        h_walk = 1'b1;
        bin_d  = bin_q + RADIX_BITS_P'(1);
        if (bin_q == '1) begin
          idx_d   = '0;
          state_d = ST_SCATTER;
        end
      end
      ST_SCATTER: begin
        h_post                      = 1'b1;
        buf_d[~sel_q][IW'(h_off_c)] = src_key;
        if (idx_q == n_q - CW'(1)) begin
          idx_d = '0;
          if (pass_q == PW'(PASSES - 1)) begin
            state_d = ST_OUT;
          end else begin
            sel_d   = ~sel_q;
            pass_d  = pass_q + PW'(1);
            state_d = ST_CLR;
          end
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_OUT: begin
        if (out_hs) begin
          if (m_tlast_q) begin
            state_d = ST_LOAD;
            n_d     = '0;
            pass_d  = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Reading buf_d picks up the final scatter write on the cycle OUT is entered.
    s_tready_d = (state_d == ST_LOAD);
    busy_d     = !((state_d == ST_LOAD) && (n_d == '0));
    m_tvalid_d = (state_d == ST_OUT);
    m_tlast_d  = (state_d == ST_OUT) && (idx_d == n_q - CW'(1));
    m_tdata_d  = (state_d == ST_OUT) ? buf_d[~sel_d][IW'(idx_d)] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_LOAD;
      n_q        <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      bin_q      <= '0;
      sel_q      <= 1'b0;
      desc_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      bin_q      <= bin_d;
      sel_q      <= sel_d;
      desc_q     <= desc_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  assign s_tready   = s_tready_q;
  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_radix_sort_lsd.sv
// Bench for radix_sort_lsd: default 16/4/16 instance plus an 8/3/16 instance for narrow-digit cases.
module tb_radix_sort_lsd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1;
  logic        descend_i = 1'b0;
  logic        use_b = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b0;

  logic        a_s_tready, a_m_tvalid, a_m_tlast, a_busy, a_ovf;
  logic [15:0] a_m_tdata;
  logic        b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_ovf;
  logic [7:0]  b_m_tdata;

  logic        o_s_tready, o_m_tvalid, o_m_tlast, o_busy, o_overflow;
  logic [15:0] o_m_tdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  logic [15:0] exp_q[$];
  int lat;
  bit tmo, bad_stall, bad_sready;

  radix_sort_lsd #(.WIDTH_P(16), .RADIX_BITS_P(4), .N_MAX_P(16)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .descend_i(descend_i),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid & ~use_b), .s_tready(a_s_tready), .s_tlast(s_tlast),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready & ~use_b), .m_tlast(a_m_tlast),
    .busy_o(a_busy), .overflow_o(a_ovf)
  );

  radix_sort_lsd #(.WIDTH_P(8), .RADIX_BITS_P(3), .N_MAX_P(16)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .descend_i(descend_i),
    .s_tdata(s_tdata[7:0]), .s_tvalid(s_tvalid & use_b), .s_tready(b_s_tready), .s_tlast(s_tlast),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready & use_b), .m_tlast(b_m_tlast),
    .busy_o(b_busy), .overflow_o(b_ovf)
  );

  assign o_s_tready = use_b ? b_s_tready : a_s_tready;
  assign o_m_tvalid = use_b ? b_m_tvalid : a_m_tvalid;
  assign o_m_tlast  = use_b ? b_m_tlast  : a_m_tlast;
  assign o_m_tdata  = use_b ? {8'h00, b_m_tdata} : a_m_tdata;
  assign o_busy     = use_b ? b_busy     : a_busy;
  assign o_overflow = use_b ? b_ovf      : a_ovf;

  // Reference: keep the first nmax keys, mask to width, stable insertion sort.
  function automatic void build_exp(input bit desc, input int nmax, input int w);
    logic [15:0] t;
    exp_q.delete();
    foreach (in_q[i]) if (i < nmax) exp_q.push_back((w == 8) ? {8'h00, in_q[i][7:0]} : in_q[i]);
    for (int i = 1; i < exp_q.size(); i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (exp_q[j-1] < exp_q[j]) : (exp_q[j-1] > exp_q[j])) begin
          t = exp_q[j-1]; exp_q[j-1] = exp_q[j]; exp_q[j] = t;
        end else break;
      end
    end
  endfunction

  task automatic send_frame(input bit desc, output int t_last, output bit busy0,
                            output bit busy1, output bit ovf1);
    int guard;
    busy0 = o_busy; busy1 = 1'b0; ovf1 = 1'b0;
    for (int i = 0; i < in_q.size(); i++) begin
      s_tvalid  = 1'b1;
      s_tdata   = in_q[i];
      s_tlast   = (i == in_q.size() - 1);
      descend_i = (i == 0) ? desc : 1'($urandom_range(0, 1));
      guard = 0;
      while (o_s_tready !== 1'b1 && guard < 200) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: s_tready=%b, required 1", o_s_tready);
        break;
      end
      @(posedge clk); #1;
      if (i == 0) begin busy1 = o_busy; ovf1 = o_overflow; end
    end
    t_last   = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic recv_frame(input bit rnd, input int t0);
    bit stalled = 1'b0;
    bit got = 1'b0;
    logic [15:0] pd = '0;
    int guard = 0;
    out_q.delete(); lat = -1; bad_stall = 1'b0; bad_sready = 1'b0;
    while (!got && guard < 3000) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && (o_m_tvalid !== 1'b1 || o_m_tdata !== pd)) bad_stall = 1'b1;
      if (o_s_tready !== 1'b0) bad_sready = 1'b1;
      if (o_m_tvalid === 1'b1) begin
        if (lat < 0) lat = cyc - t0;
        if (m_tready) begin
          out_q.push_back(o_m_tdata);
          got = (o_m_tlast === 1'b1);
        end
      end
      stalled = (o_m_tvalid === 1'b1) && !m_tready;
      pd = o_m_tdata;
      @(posedge clk); #1; guard++;
    end
    m_tready = 1'b0;
    tmo = !got;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({a_s_tready, a_m_tvalid, a_m_tlast, a_busy, a_ovf} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl_a: got %b required 00000", {a_s_tready, a_m_tvalid, a_m_tlast, a_busy, a_ovf});
    end
    n_cmp++; if (a_m_tdata !== 16'h0) begin n_err++; $display("FAIL reset_tdata_a: got %h required 0000", a_m_tdata); end
    n_cmp++; if ({b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_ovf, b_m_tdata} !== 13'b0) begin
      n_err++; $display("FAIL reset_b: got %b required 0", {b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_ovf, b_m_tdata});
    end
    reset_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_s_tready !== 1'b1) begin n_err++; $display("FAIL reset_sready_after: got %b required 1", a_s_tready); end
  endtask

  task automatic test_ascending;
    int t; bit b0, b1, ov;
    in_q = '{16'h1A3, 16'h000, 16'h3FF, 16'h155, 16'h02A, 16'h200, 16'h0F0, 16'h001, 16'h3FE, 16'h100};
    send_frame(1'b0, t, b0, b1, ov);
    n_cmp++; if (b0 !== 1'b0 || b1 !== 1'b1) begin n_err++; $display("FAIL asc_busy: before/after %b/%b required 0/1", b0, b1); end
    recv_frame(1'b0, t);
    build_exp(1'b0, 16, 16);
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL asc_timeout: got %b required 0", tmo); end
    // First m_tvalid is visible in the 149th cycle after the tlast edge: 4*(2*10+16+1) edges later.
    n_cmp++; if (lat !== 148) begin n_err++; $display("FAIL asc_latency: got %0d required 148", lat); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL asc_count: got %0d required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL asc_key[%0d]: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_cmp++; if (exp_q[9] !== 16'h3FF || exp_q[0] !== 16'h000) begin n_err++; $display("FAIL asc_model: got %h..%h required 000..3FF", exp_q[0], exp_q[9]); end
    n_cmp++; if (o_s_tready !== 1'b1 || o_busy !== 1'b0) begin n_err++; $display("FAIL asc_post_idle: sready/busy %b/%b required 1/0", o_s_tready, o_busy); end
  endtask

  task automatic test_descending;
    int t; bit b0, b1, ov;
    in_q = '{16'h1A3, 16'h000, 16'h3FF, 16'h155, 16'h02A, 16'h200, 16'h0F0, 16'h001, 16'h3FE, 16'h100};
    send_frame(1'b1, t, b0, b1, ov);
    recv_frame(1'b0, t);
    build_exp(1'b1, 16, 16);
    n_cmp++; if (tmo !== 1'b0 || out_q.size() !== 10) begin n_err++; $display("FAIL desc_count: got %0d required 10", out_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL desc_key[%0d]: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_stability;
    int t; bit b0, b1, ov; bit desc;
    use_b = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 3; f++) begin
      in_q.delete();
      if (f == 0) begin
        in_q = '{16'h15, 16'h05, 16'h15, 16'h05};
        desc = 1'b0;
      end else begin
        for (int k = 0; k < 12; k++) in_q.push_back(16'($urandom));
        desc = 1'(f - 1);
      end
      send_frame(desc, t, b0, b1, ov);
      recv_frame(1'b0, t);
      build_exp(desc, 16, 8);
      n_cmp++; if (tmo !== 1'b0 || out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL stab%0d_count: got %0d required %0d", f, out_q.size(), exp_q.size()); end
      n_cmp++; if (lat !== 3 * (2 * in_q.size() + 9)) begin n_err++; $display("FAIL stab%0d_latency: got %0d required %0d", f, lat, 3 * (2 * in_q.size() + 9)); end
      foreach (exp_q[i]) begin
        n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL stab%0d_key[%0d]: got %h required %h", f, i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
        end
      end
    end
    use_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int t; bit b0, b1, ov;
    in_q.delete();
    for (int k = 17; k >= 0; k--) in_q.push_back(16'(k));
    send_frame(1'b0, t, b0, b1, ov);
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b required 1", o_overflow); end
    recv_frame(1'b0, t);
    build_exp(1'b0, 16, 16);
    n_cmp++; if (tmo !== 1'b0 || out_q.size() !== 16) begin n_err++; $display("FAIL ovf_count: got %0d required 16", out_q.size()); end
    n_cmp++; if (lat !== 4 * (32 + 17)) begin n_err++; $display("FAIL ovf_latency: got %0d required %0d", lat, 4 * (32 + 17)); end
    foreach (exp_q[i]) begin
      n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ovf_key[%0d]: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", o_overflow); end
    in_q = '{16'h0009, 16'hFFFF, 16'h0100, 16'h0009, 16'h8000};
    send_frame(1'b0, t, b0, b1, ov);
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL ovf_clear_first_beat: got %b required 0", ov); end
    recv_frame(1'b0, t);
    build_exp(1'b0, 16, 16);
    n_cmp++; if (tmo !== 1'b0 || out_q.size() !== 5) begin n_err++; $display("FAIL ovf_next_count: got %0d required 5", out_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ovf_next_key[%0d]: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int t; bit b0, b1, ov; bit desc;
    for (int f = 0; f < 3; f++) begin
      in_q.delete();
      for (int k = 0; k < 16; k++) in_q.push_back(16'($urandom));
      desc = 1'($urandom_range(0, 1));
      send_frame(desc, t, b0, b1, ov);
      recv_frame(1'b1, t);
      build_exp(desc, 16, 16);
      n_cmp++; if (bad_stall !== 1'b0) begin n_err++; $display("FAIL bp%0d_stall_stable: got %b required 0", f, bad_stall); end
      n_cmp++; if (bad_sready !== 1'b0) begin n_err++; $display("FAIL bp%0d_sready_low: got %b required 0", f, bad_sready); end
      n_cmp++; if (tmo !== 1'b0 || out_q.size() !== 16) begin n_err++; $display("FAIL bp%0d_count: got %0d required 16", f, out_q.size()); end
      foreach (exp_q[i]) begin
        n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL bp%0d_key[%0d]: got %h required %h", f, i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int t, n; bit b0, b1, ov; bit desc;
    for (int f = 0; f < 6; f++) begin
      n = (f == 0) ? 1 : $urandom_range(1, 16);
      in_q.delete();
      for (int k = 0; k < n; k++) in_q.push_back(16'($urandom));
      desc = 1'($urandom_range(0, 1));
      send_frame(desc, t, b0, b1, ov);
      recv_frame(1'b0, t);
      build_exp(desc, 16, 16);
      n_cmp++; if (lat !== 4 * (2 * n + 17)) begin n_err++; $display("FAIL b2b%0d_latency: got %0d required %0d", f, lat, 4 * (2 * n + 17)); end
      n_cmp++; if (tmo !== 1'b0 || out_q.size() !== n) begin n_err++; $display("FAIL b2b%0d_count: got %0d required %0d", f, out_q.size(), n); end
      foreach (exp_q[i]) begin
        n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL b2b%0d_key[%0d]: got %h required %h", f, i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int t; bit b0, b1, ov; bit seen;
    in_q.delete();
    for (int k = 0; k < 10; k++) in_q.push_back(16'($urandom));
    send_frame(1'b0, t, b0, b1, ov);
    // Second pass scatters during the cycles after edges t+64..t+73.
    while (cyc < t + 68) begin @(posedge clk); #1; end
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    n_cmp++; if ({o_s_tready, o_m_tvalid, o_m_tlast, o_busy} !== 4'b0 || o_m_tdata !== 16'h0) begin
      n_err++; $display("FAIL rstmid_values: ctrl %b data %h required 0000/0000", {o_s_tready, o_m_tvalid, o_m_tlast, o_busy}, o_m_tdata);
    end
    seen = 1'b0;
    m_tready = 1'b1;
    repeat (200) begin @(posedge clk); #1; if (o_m_tvalid !== 1'b0) seen = 1'b1; end
    m_tready = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_output: got %b required 0", seen); end
    in_q = '{16'd5, 16'd3, 16'd4};
    send_frame(1'b0, t, b0, b1, ov);
    recv_frame(1'b0, t);
    exp_q = '{16'd3, 16'd4, 16'd5};
    n_cmp++; if (tmo !== 1'b0 || out_q.size() !== 3) begin n_err++; $display("FAIL rstmid_count: got %0d required 3", out_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++; if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rstmid_key[%0d]: got %h required %h", i, (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ascending;
    test_descending;
    test_stability;
    test_overflow;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
